// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD digit limits and BCD time arithmetic for stopwatch_lap.
package stopwatch_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_RECALL, ST_ALARM} state_t;

    localparam logic [3:0] LIM_CL = 4'd9;
    localparam logic [3:0] LIM_CH = 4'd9;
    localparam logic [3:0] LIM_SL = 4'd9;
    localparam logic [3:0] LIM_SH = 4'd5;
    localparam logic [3:0] LIM_ML = 4'd9;
    localparam logic [3:0] LIM_MH = 4'd5;
    localparam logic [23:0] DIGIT_MAX = {LIM_MH, LIM_ML, LIM_SH, LIM_SL, LIM_CH, LIM_CL};

    typedef struct packed {
        logic [3:0] mh;
        logic [3:0] ml;
        logic [3:0] sh;
        logic [3:0] sl;
        logic [3:0] ch;
        logic [3:0] cl;
    } bcd_time_t;

    function automatic bcd_time_t bcd_step(input bcd_time_t t, input logic down, output logic c);
        logic [23:0] v;
        logic [3:0] d;
        logic [3:0] lim;
        v = t;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = v[i*4 +: 4];
            lim = DIGIT_MAX[i*4 +: 4];
            if (c) begin
                c = down ? (d == 4'd0) : (d == lim);
                d = down ? (c ? lim : d - 4'd1) : (c ? 4'd0 : d + 4'd1);
            end
            v[i*4 +: 4] = d;
        end
        return bcd_time_t'(v);
    endfunction

    function automatic bcd_time_t bcd_sanitize(input logic [23:0] p);
        logic [23:0] v;
        for (int i = 0; i < 6; i++)
            v[i*4 +: 4] = (p[i*4 +: 4] > DIGIT_MAX[i*4 +: 4]) ? 4'd0 : p[i*4 +: 4];
        return bcd_time_t'(v);
    endfunction

endpackage

// File: rtl/stopwatch_lap_key_debounce.sv
// key_debounce: synchronises an active-low key, accepts a new level after a stable run, pulses on each accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic key_reset,
    input  logic key_n,
    output logic pressed_pulse,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic          flip;

    always_comb begin
        sync_d  = {sync_q[0], key_n};
        flip    = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d   = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
        level_d = flip ? sync_q[1] : level_q;
        pulse_d = flip && !sync_q[1];
    end

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pressed_pulse = pulse_q;
    assign level         = level_q;

endmodule

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: MM:SS.cc up/down stopwatch with debounced keys and a circular lap memory with recall.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50000000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LAP_DEPTH       = 8,
    localparam int LAP_AW         = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              key_reset,
    input  logic              key_start_pause,
    input  logic              key_lap,
    input  logic              key_mode,
    input  logic [23:0]       preset_bcd,
    output logic [23:0]       digits,
    output logic [LAP_AW:0]   lap_count,
    output logic [LAP_AW-1:0] lap_index,
    output logic              mode_down,
    output logic              running,
    output logic              alarm
);

    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);

    if (TICK_DIV < 2 || TICK_DIV * TICK_HZ != CLK_FREQ_HZ) begin : g_bad_tick_div
        $error("stopwatch_lap: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
    end
    if (LAP_DEPTH < 2 || (LAP_DEPTH & (LAP_DEPTH - 1)) != 0) begin : g_bad_lap_depth
        $error("stopwatch_lap: LAP_DEPTH must be a power of two >= 2");
    end

    logic [2:0] pulse, level, press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .key_reset(key_reset), .key_n(key_start_pause), .pressed_pulse(pulse[0]), .level(level[0])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk(clk), .key_reset(key_reset), .key_n(key_lap), .pressed_pulse(pulse[1]), .level(level[1])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .key_reset(key_reset), .key_n(key_mode), .pressed_pulse(pulse[2]), .level(level[2])
    );

    assign press = pulse & ~level;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    bcd_time_t         cnt_q, cnt_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [LAP_AW-1:0] wr_q, wr_d;
    logic [LAP_AW:0]   lcnt_q, lcnt_d;
    logic [LAP_AW-1:0] idx_q, idx_d;
    bcd_time_t         digits_q, digits_d;
    bcd_time_t         lap_mem [LAP_DEPTH];
    bcd_time_t         stepped, preset_s;
    logic [LAP_AW-1:0] rd_ptr;
    logic              tick, cy, lap_we, ps, pl, pm;

    always_comb begin
        ps       = press[0];
        pl       = press[1] & ~press[0];
        pm       = press[2] & ~|press[1:0];
        tick     = (state_q == ST_RUN) && (pre_q == PW'(TICK_DIV - 1));
        stepped  = bcd_step(cnt_q, mode_q, cy);
        preset_s = bcd_sanitize(preset_bcd);
        rd_ptr   = wr_q - LAP_AW'(1) - idx_q;
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        wr_d     = wr_q;
        lcnt_d   = lcnt_q;
        idx_d    = idx_q;
        lap_we   = 1'b0;
        if (state_q == ST_RUN) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            cnt_d = tick ? stepped : cnt_q;
            // a borrow out of 00:00.00 also ends the countdown rather than wrapping to 59:59.99
            if (tick && mode_q && (stepped == '0 || cy)) begin
                state_d = ST_ALARM;
                cnt_d   = '0;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (ps) begin
                    state_d = (mode_q && preset_s == '0) ? ST_ALARM : ST_RUN;
                    cnt_d   = mode_q ? preset_s : '0;
                    pre_d   = '0;
                end else if (pm) begin
                    mode_d = ~mode_q;
                    cnt_d  = mode_q ? '0 : preset_s;
                end
            end
            ST_RUN: begin
                if (ps) begin
                    state_d = ST_PAUSE;
                end else if (pl) begin
                    lap_we = 1'b1;
                    wr_d   = wr_q + 1'b1;
                    lcnt_d = (lcnt_q == (LAP_AW + 1)'(LAP_DEPTH)) ? lcnt_q : lcnt_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (ps) begin
                    state_d = ST_RUN;
                end else if (pl && lcnt_q != '0) begin
                    state_d = ST_RECALL;
                    idx_d   = '0;
                end else if (pm) begin
                    state_d = ST_IDLE;
                    cnt_d   = mode_q ? preset_s : '0;
                    lcnt_d  = '0;
                    wr_d    = '0;
                    idx_d   = '0;
                end
            end
            ST_RECALL: begin
                if (ps || (pl && {1'b0, idx_q} == lcnt_q - 1'b1)) begin
                    state_d = ST_PAUSE;
                    idx_d   = '0;
                end else if (pl) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_ALARM: begin
                if (|press) begin
                    state_d = ST_IDLE;
                    cnt_d   = mode_q ? preset_s : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        digits_d = (state_q == ST_RECALL) ? lap_mem[rd_ptr] : (state_q == ST_ALARM) ? '0 : cnt_q;
    end

    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            pre_q    <= '0;
            wr_q     <= '0;
            lcnt_q   <= '0;
            idx_q    <= '0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            wr_q     <= wr_d;
            lcnt_q   <= lcnt_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lap_we) lap_mem[wr_q] <= cnt_q;
    end

    assign digits    = digits_q;
    assign lap_count = lcnt_q;
    assign lap_index = idx_q;
    assign mode_down = mode_q;
    assign running   = (state_q == ST_RUN);
    assign alarm     = (state_q == ST_ALARM);

endmodule
